// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one external combinational signed divider between two
// requesters. Grants round-robin, registers the divider operands, waits a fixed
// settle window, captures quotient/remainder and returns them on a valid/ready
// response channel. The overflow case (MIN / -1) never uses the divider.
//
// Optional feature macro: DIV_ZERO_TRAP_EN
//   defined   - divisor 0 bypasses the divider: q = all ones, r = dividend, dbz = 1
//   undefined - divisor 0 takes the normal settle path, resp_div_by_zero stays 0
//
// Ports:
//   clock, clear_n                 clock (rising edge), async active-low reset
//   req0_* / req1_*                requester valid/ready + signed operands a, b
//   div_a, div_b                   registered operands driving the divider
//   div_quotient, div_remainder    divider results
//   resp_valid/ready/id            response handshake and owning requester
//   resp_quotient/remainder        result, resp_div_by_zero flag
//   busy                           high whenever not idle
module div_share_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_quotient,
  output logic [WIDTH-1:0] resp_remainder,
  output logic             resp_div_by_zero,
  output logic             busy
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ptr;          // 0: requester 0 favoured
  logic               w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   r_div_a;
  logic [WIDTH-1:0]   w_div_a_nxt;
  logic [WIDTH-1:0]   r_div_b;
  logic [WIDTH-1:0]   w_div_b_nxt;
  logic               r_resp_id;
  logic               w_resp_id_nxt;
  logic [WIDTH-1:0]   r_resp_q;
  logic [WIDTH-1:0]   w_resp_q_nxt;
  logic [WIDTH-1:0]   r_resp_r;
  logic [WIDTH-1:0]   w_resp_r_nxt;
  logic               r_resp_dbz;
  logic               w_resp_dbz_nxt;

  logic               w_grant_vld;
  logic               w_grant_id;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_ovf;
  logic               w_zero_trap;

  // Round-robin pick: favoured requester first, otherwise the other one.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (r_ptr == 1'b0) begin
      if (req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end else if (req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end
    end else begin
      if (req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end else if (req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end
    end
  end

  assign w_xfer     = (r_state == ST_IDLE) && w_grant_vld;
  assign req0_ready = w_xfer && !w_grant_id;
  assign req1_ready = w_xfer &&  w_grant_id;

  assign w_sel_a = w_grant_id ? req1_a : req0_a;
  assign w_sel_b = w_grant_id ? req1_b : req0_b;

  // MIN / -1 is not representable; answered directly with saturated quotient.
  assign w_ovf = (w_sel_a == MIN_NEG) && (w_sel_b == '1);

`ifdef DIV_ZERO_TRAP_EN
  assign w_zero_trap = (w_sel_b == '0);
`else
  assign w_zero_trap = 1'b0;
`endif

  // Next-state and datapath next values.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_div_a_nxt    = r_div_a;
    w_div_b_nxt    = r_div_b;
    w_resp_id_nxt  = r_resp_id;
    w_resp_q_nxt   = r_resp_q;
    w_resp_r_nxt   = r_resp_r;
    w_resp_dbz_nxt = r_resp_dbz;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_div_a_nxt   = w_sel_a;
          w_div_b_nxt   = w_sel_b;
          w_resp_id_nxt = w_grant_id;
          w_ptr_nxt     = ~w_grant_id;
          if (w_ovf) begin
            w_resp_q_nxt   = MIN_NEG;
            w_resp_r_nxt   = '0;
            w_resp_dbz_nxt = 1'b0;
            w_state_nxt    = ST_RESP;
          end else if (w_zero_trap) begin
            w_resp_q_nxt   = '1;
            w_resp_r_nxt   = w_sel_a;
            w_resp_dbz_nxt = 1'b1;
            w_state_nxt    = ST_RESP;
          end else begin
            w_resp_dbz_nxt = 1'b0;
            w_cnt_nxt      = CNT_LOAD;
            w_state_nxt    = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        // Operands have been stable for the full window when the count hits 0.
        if (r_cnt == '0) begin
          w_resp_q_nxt = div_quotient;
          w_resp_r_nxt = div_remainder;
          w_state_nxt  = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_cnt      <= '0;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_resp_id  <= 1'b0;
      r_resp_q   <= '0;
      r_resp_r   <= '0;
      r_resp_dbz <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_a    <= w_div_a_nxt;
      r_div_b    <= w_div_b_nxt;
      r_resp_id  <= w_resp_id_nxt;
      r_resp_q   <= w_resp_q_nxt;
      r_resp_r   <= w_resp_r_nxt;
      r_resp_dbz <= w_resp_dbz_nxt;
    end
  end

  assign div_a            = r_div_a;
  assign div_b            = r_div_b;
  assign resp_valid       = (r_state == ST_RESP);
  assign resp_id          = r_resp_id;
  assign resp_quotient    = r_resp_q;
  assign resp_remainder   = r_resp_r;
  assign resp_div_by_zero = r_resp_dbz;
  assign busy             = (r_state != ST_IDLE);

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Sequencer and arbiter that shares the single combinational signed 32-bit divider between two requesters, for example the CPU control unit and a debug/test port. It grants requests round-robin and registers the operands that drive the divider. It waits a fixed multicycle settle window, captures quotient and remainder, and returns them on a valid/ready response channel. Degenerate operands are handled without using the divider.

Parameters:
WIDTH, 32, operand/result width; must match divider width
SETTLE_CYCLES, 4, clock cycles the divider inputs are held stable before results are sampled; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  WIDTH  requester 0 dividend (signed)
req0_b  in  WIDTH  requester 0 divisor (signed)
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  WIDTH  requester 1 dividend
req1_b  in  WIDTH  requester 1 divisor
div_a  out  WIDTH  registered dividend to divider
div_b  out  WIDTH  registered divisor to divider
div_quotient  in  WIDTH  divider quotient
div_remainder  in  WIDTH  divider remainder
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  1  requester that owns the response
resp_quotient  out  WIDTH  result quotient
resp_remainder  out  WIDTH  result remainder
resp_div_by_zero  out  1  divisor was zero
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SETTLE, RESP. Reset (clear_n low, asynchronous) forces IDLE immediately, mid-operation included. In-flight work is discarded.
- Reset values: all outputs 0; settle counter 0; round-robin pointer set to favour requester 0.
- IDLE grant rule: the requester favoured by the pointer wins if its valid is high; otherwise the other requester wins if its valid is high.
- reqN_ready is combinational and is high only in IDLE for the granted requester. At most one ready is high per cycle. A transfer occurs on valid & ready.
- On a transfer edge:
  - div_a/div_b load the granted operands; resp_id loads the grant.
  - The pointer moves to favour the non-granted requester.
- Routing after a transfer:
  - Divisor 0 (see Optional Feature) or overflow (a = 0x80000000, b = 0xFFFFFFFF) → RESP directly. The response is visible 1 cycle after acceptance.
  - Otherwise → SETTLE with counter = SETTLE_CYCLES-1.
- Overflow result: quotient 0x80000000, remainder 0, resp_div_by_zero 0.
- SETTLE:
  - div_a/div_b are held constant.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, div_quotient/div_remainder are captured into resp_quotient/resp_remainder and the block enters RESP.
  - Latency from acceptance edge to resp_valid high = SETTLE_CYCLES cycles.
- RESP:
  - resp_valid is high, and resp_* stay stable until resp_valid & resp_ready.
  - On that edge the block enters IDLE and resp_valid drops.
  - No new request is accepted in the same cycle; the next grant is possible the following cycle, which gives one idle cycle of arbitration.
- resp_valid waits indefinitely for resp_ready; the requester's valid may stay high and is not granted meanwhile.
- Results are signed two's complement. The remainder takes the dividend's sign; the controller never alters divider outputs except in bypass cases.
- Both valids high continuously: grants alternate 0,1,0,1…

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- Defined: b == 0 bypasses the divider. The response arrives 1 cycle after acceptance with resp_div_by_zero = 1, quotient 0xFFFFFFFF and remainder = a.
- Undefined: b == 0 follows the normal SETTLE path and returns whatever the divider produces. resp_div_by_zero is tied 0.

Test Plan:
- req0 a = 100, b = 7, SETTLE_CYCLES = 4, resp_ready = 1 → resp_valid 4 cycles after acceptance; q = 14, r = 2, resp_id = 0.
- req1 a = -100, b = 7 → q = -14 (0xFFFFFFF2), r = -2 (0xFFFFFFFE), resp_id = 1.
- Both valids held high for 4 transactions → grants 0,1,0,1; each ready is a single-cycle pulse.
- resp_ready low for 10 cycles in RESP → resp_* stable and busy = 1; the other requester is not granted until the response is accepted.
- With DIV_ZERO_TRAP_EN, a = 55, b = 0 → response 1 cycle after acceptance: dbz = 1, q = 0xFFFFFFFF, r = 55. Overflow case a = 0x80000000, b = -1 → q = 0x80000000, r = 0.
- clear_n pulsed low during SETTLE → outputs 0 and state IDLE immediately. The next request completes normally with the pointer favouring requester 0.
